call_return_ctrl: RTL and testbench

Subroutine-linkage sequencer that drives the push/pop side of the 8-bit `Stack` block. On a CALL it pushes the return address (PC+1) and redirects the PC to the call target. On a RET it pops the saved address and hands it back to the PC register. The block sits between the control unit / PC logic and `Stack`. It owns `StackWrite`/`StackRead`, tracks stack occupancy, and flags overflow/underflow.

---
 rtl/call_return_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_call_return_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_return_ctrl.sv
// -----------------------------------------------------------------------------
// call_return_ctrl
//
// Subroutine-linkage sequencer sitting between the control unit / PC logic and
// an external Stack block. A CALL pushes the return address (PC+1) and redirects
// the PC to Target. A RET pops the saved address and hands it back to the PC.
// The block owns the Stack push/pop strobes, tracks occupancy and flags
// refused requests.
//
// Parameters:
//   WIDTH  - address/data width (matches Stack data width)
//   DEPTH  - stack capacity in entries
//   RD_LAT - cycles from the edge sampling StackRead to the edge on which
//            StackRData is valid (1..4)
//
// Ports:
//   clk, Reset        - clock, asynchronous active-high reset
//   Call, Ret         - requests, sampled only while idle (CALL has priority)
//   PC, Target        - current program counter, call destination
//   StackWrite/Read   - push / pop strobes to Stack (never high together)
//   StackWData        - push data (return address), held between pushes
//   StackRData        - pop data from Stack
//   PCLoad, PCNext    - one-cycle load strobe and registered new PC value
//   Busy              - high whenever the sequencer is not idle
//   Depth             - current stack occupancy
//   Overflow          - sticky: a CALL was refused on a full stack
//   Underflow         - sticky: a RET was refused on an empty stack
// -----------------------------------------------------------------------------
module call_return_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                           clk,
    input  logic                           Reset,
    input  logic                           Call,
    input  logic                           Ret,
    input  logic [WIDTH-1:0]               PC,
    input  logic [WIDTH-1:0]               Target,
    output logic                           StackWrite,
    output logic                           StackRead,
    output logic [WIDTH-1:0]               StackWData,
    input  logic [WIDTH-1:0]               StackRData,
    output logic                           PCLoad,
    output logic [WIDTH-1:0]               PCNext,
    output logic                           Busy,
    output logic [$clog2(DEPTH+1)-1:0]     Depth,
    output logic                           Overflow,
    output logic                           Underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    // Wide enough for RD_LAT up to 4.
    localparam int CW = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POPREQ,
        S_WAIT,
        S_LOAD
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   pcnext_q, pcnext_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [CW-1:0]      wait_cnt_q, wait_cnt_d;

    logic               full;
    logic               empty;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            wdata_q    <= '0;
            pcnext_q   <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wdata_q    <= wdata_d;
            pcnext_q   <= pcnext_d;
            depth_q    <= depth_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        pcnext_d   = pcnext_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                // CALL has priority; a simultaneous RET is dropped, even when
                // the CALL itself is refused.
                if (Call) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wdata_d  = PC + WIDTH'(1);
                        pcnext_d = Target;
                        state_d  = S_PUSH;
                    end
                end else if (Ret) begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        state_d = S_POPREQ;
                    end
                end
            end

            S_PUSH: begin
                depth_d = depth_q + DW'(1);
                state_d = S_IDLE;
            end

            S_POPREQ: begin
                depth_d    = depth_q - DW'(1);
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                // Last WAIT cycle coincides with the edge on which Stack
                // presents the popped value.
                if (wait_cnt_q == CW'(RD_LAT - 1)) begin
                    pcnext_d = StackRData;
                    state_d  = S_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end

            S_LOAD: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore outputs
    // -------------------------------------------------------------------------
    assign StackWrite = (state_q == S_PUSH);
    assign StackRead  = (state_q == S_POPREQ);
    assign PCLoad     = (state_q == S_PUSH) || (state_q == S_LOAD);
    assign Busy       = (state_q != S_IDLE);

    assign StackWData = wdata_q;
    assign PCNext     = pcnext_q;
    assign Depth      = depth_q;
    assign Overflow   = ovf_q;
    assign Underflow  = unf_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
module tb_call_return_ctrl;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int RD_LAT  = 2;
    localparam int RET_LAT = RD_LAT + 2;   // observed cycle index of PCLoad for a RET

    logic             clk;
    logic             Reset;
    logic             Call;
    logic             Ret;
    logic [7:0]       PC;
    logic [7:0]       Target;
    logic             StackWrite;
    logic             StackRead;
    logic [7:0]       StackWData;
    logic [7:0]       StackRData;
    logic             PCLoad;
    logic [7:0]       PCNext;
    logic             Busy;
    logic [2:0]       Depth;
    logic             Overflow;
    logic             Underflow;

    int total = 0;
    int bad   = 0;

    call_return_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Call       (Call),
        .Ret        (Ret),
        .PC         (PC),
        .Target     (Target),
        .StackWrite (StackWrite),
        .StackRead  (StackRead),
        .StackWData (StackWData),
        .StackRData (StackRData),
        .PCLoad     (PCLoad),
        .PCNext     (PCNext),
        .Busy       (Busy),
        .Depth      (Depth),
        .Overflow   (Overflow),
        .Underflow  (Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Stack with a RD_LAT-deep read pipeline; non-read cycles
    // present a marker value so an early capture is visible.
    logic [7:0] smem [16];
    int         sp;
    logic [7:0] pipe [RD_LAT];

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sp <= 0;
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= 8'hEE;
        end else begin
            if (StackWrite) begin
                smem[sp] <= StackWData;
                sp <= sp + 1;
            end else if (StackRead && sp > 0) begin
                sp <= sp - 1;
            end
            pipe[0] <= (StackRead && sp > 0) ? smem[sp-1] : 8'hEE;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign StackRData = pipe[RD_LAT-1];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of return addresses plus sticky flags.
    logic [7:0] mq[$];
    logic       m_ovf, m_unf;
    logic [7:0] m_wd, m_pcn;

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_wd  = 8'h00;
        m_pcn = 8'h00;
    endtask

    task automatic model_req(input logic c, input logic r, input logic [7:0] pc,
                             input logic [7:0] tgt, output int lat);
        lat = 0;
        if (c) begin
            if (mq.size() == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                m_wd  = pc + 8'd1;
                m_pcn = tgt;
                mq.push_back(m_wd);
                lat = 1;
            end
        end else if (r) begin
            if (mq.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_pcn = mq.pop_back();
                lat = RET_LAT;
            end
        end
    endtask

    task automatic apply_reset();
        Call  = 1'b0;
        Ret   = 1'b0;
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stackwrite"}, StackWrite, 0);
        check({tag, "_stackread"},  StackRead,  0);
        check({tag, "_pcload"},     PCLoad,     0);
        check({tag, "_busy"},       Busy,       0);
        check({tag, "_depth"},      Depth,      0);
        check({tag, "_pcnext"},     PCNext,     0);
        check({tag, "_wdata"},      StackWData, 0);
        check({tag, "_overflow"},   Overflow,   0);
        check({tag, "_underflow"},  Underflow,  0);
    endtask

    // Present one request for one edge, then follow it until the FSM is idle.
    task automatic do_req(input logic c, input logic r, input logic [7:0] pc,
                          input logic [7:0] tgt, output int lat, output logic [7:0] pcn,
                          output logic [7:0] wd, output logic sw, output logic sr,
                          output logic bsy, output logic excl);
        lat = 0; pcn = 8'h00; wd = 8'h00; sw = 0; sr = 0; bsy = 0; excl = 0;
        @(negedge clk);
        Call = c; Ret = r; PC = pc; Target = tgt;
        @(posedge clk);
        #1;
        Call = 1'b0; Ret = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (StackWrite && StackRead) excl = 1;
            if (StackWrite) begin sw = 1; wd = StackWData; end
            if (StackRead) sr = 1;
            if (PCLoad) begin
                lat = (lat == 0) ? i : -1;
                pcn = PCNext;
            end
            if (Busy) bsy = 1;
            else break;
        end
        check("idle_after_req", Busy, 0);
    endtask

    task automatic compare_req(input string tag, input int lat, input logic [7:0] pcn,
                               input logic [7:0] wd, input logic sw, input logic sr,
                               input logic bsy, input logic excl,
                               input int e_lat, input logic [7:0] e_pcn, input logic [7:0] e_wd,
                               input int e_dep, input logic e_ovf, input logic e_unf);
        check({tag, "_load_cycle"}, lat, e_lat);
        check({tag, "_push_strobe"}, sw, (e_lat == 1) ? 1 : 0);
        check({tag, "_pop_strobe"}, sr, (e_lat == RET_LAT) ? 1 : 0);
        check({tag, "_busy"}, bsy, (e_lat != 0) ? 1 : 0);
        check({tag, "_wr_rd_excl"}, excl, 0);
        if (e_lat != 0) check({tag, "_load_pcnext"}, pcn, e_pcn);
        if (e_lat == 1) check({tag, "_push_wdata"}, wd, e_wd);
        check({tag, "_depth"}, Depth, e_dep);
        check({tag, "_overflow"}, Overflow, e_ovf);
        check({tag, "_underflow"}, Underflow, e_unf);
        check({tag, "_pcnext_held"}, PCNext, e_pcn);
        check({tag, "_wdata_held"}, StackWData, e_wd);
    endtask

    typedef struct {
        logic       c;
        logic       r;
        logic [7:0] pc;
        logic [7:0] tgt;
        int         lat;
        logic [7:0] pcn;
        logic [7:0] wd;
        int         dep;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl [14];

    int         lat;
    logic [7:0] pcn, wd;
    logic       sw, sr, bsy, excl;
    int         e_lat;
    int         loads;
    logic       seen_read;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, 0,       8'h00, 8'h00, 0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 8'h10, 8'h40, 1,       8'h40, 8'h11, 1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 8'h20, 8'h50, 1,       8'h50, 8'h21, 2, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 8'h30, 8'h60, 1,       8'h60, 8'h31, 3, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 8'h00, RET_LAT, 8'h31, 8'h31, 2, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 8'h00, RET_LAT, 8'h21, 8'h31, 1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 8'h00, RET_LAT, 8'h11, 8'h31, 0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 8'hFF, 8'h01, 1,       8'h01, 8'h00, 1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 8'h01, 8'h02, 1,       8'h02, 8'h02, 2, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 8'h02, 8'h03, 1,       8'h03, 8'h03, 3, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 8'h03, 8'h04, 1,       8'h04, 8'h04, 4, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 8'h04, 8'h05, 0,       8'h04, 8'h04, 4, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 8'h05, 8'h06, 0,       8'h04, 8'h04, 4, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'h00, 8'h00, RET_LAT, 8'h04, 8'h04, 3, 1'b1, 1'b1};

        PC = 8'h00; Target = 8'h00;
        apply_reset();
        check_reset_values("reset");

        // Directed table
        for (int i = 0; i < 14; i++) begin
            do_req(tbl[i].c, tbl[i].r, tbl[i].pc, tbl[i].tgt, lat, pcn, wd, sw, sr, bsy, excl);
            compare_req($sformatf("tbl%0d", i), lat, pcn, wd, sw, sr, bsy, excl,
                        tbl[i].lat, tbl[i].pcn, tbl[i].wd, tbl[i].dep, tbl[i].ovf, tbl[i].unf);
        end

        // Call and Ret together with one entry stacked; Ret held through PUSH.
        apply_reset();
        do_req(1'b1, 1'b0, 8'h10, 8'h40, lat, pcn, wd, sw, sr, bsy, excl);
        compare_req("both_pre", lat, pcn, wd, sw, sr, bsy, excl, 1, 8'h40, 8'h11, 1, 1'b0, 1'b0);
        @(negedge clk);
        Call = 1'b1; Ret = 1'b1; PC = 8'h22; Target = 8'h70;
        @(posedge clk);
        #1;
        Call = 1'b0;
        @(negedge clk);
        check("both_push_strobe", StackWrite, 1);
        check("both_no_read", StackRead, 0);
        check("both_pcnext", PCNext, 8'h70);
        check("both_wdata", StackWData, 8'h23);
        @(posedge clk);
        #1;
        Ret = 1'b0;
        seen_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (StackRead || Busy) seen_read = 1'b1;
        end
        check("both_ret_ignored", seen_read, 0);
        check("both_depth", Depth, 2);

        // Reset pulsed while waiting for the pop data.
        @(negedge clk);
        Ret = 1'b1;
        @(posedge clk);
        #1;
        Ret = 1'b0;
        @(negedge clk);
        check("abort_popreq", StackRead, 1);
        @(negedge clk);
        check("abort_wait_busy", Busy, 1);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        Reset = 1'b0;
        loads = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (PCLoad) loads++;
        end
        check("abort_no_pcload", loads, 0);
        check("abort_idle", Busy, 0);
        check("abort_depth", Depth, 0);

        // Randomized requests against the queue model.
        apply_reset();
        model_reset();
        for (int n = 0; n < 150; n++) begin
            logic       c, r;
            logic [7:0] pc, tgt;
            c   = ($urandom_range(0, 99) < 45);
            r   = ($urandom_range(0, 99) < 50);
            pc  = 8'($urandom);
            tgt = 8'($urandom);
            model_req(c, r, pc, tgt, e_lat);
            do_req(c, r, pc, tgt, lat, pcn, wd, sw, sr, bsy, excl);
            compare_req($sformatf("rnd%0d", n), lat, pcn, wd, sw, sr, bsy, excl,
                        e_lat, m_pcn, m_wd, mq.size(), m_ovf, m_unf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
